return_stack_ctrl: RTL
======================

// Module: return_stack_ctrl
// PURPOSE
//  Hardware return-address stack controller for the 16-bit pipeline.
//  CALL/RET are decoded in ID; return address on CALL is pushed, top entry is popped on RET.
//  Popped address is registered into EX as Stack_Out_EX with Stack_Out_Enable_EX, which steer
//  the EX-stage branch-address select (stack vs immediate). Flags overflow/underflow.
// PARAMETERS
//  ADDR_W  16  width of return address / Stack_Out_EX
//  DEPTH    8  number of stack entries (power of 2, >=2); count width CNT_W = $clog2(DEPTH)+1
// PORTS
//  clk                  in   1       rising-edge clock
//  rst                  in   1       synchronous, active-high reset
//  Call_ID              in   1       CALL in ID: push Return_Addr_ID
//  Ret_ID               in   1       RET in ID: pop top to EX
//  Return_Addr_ID       in   ADDR_W  return address (PC+1) for CALL
//  Stall                in   1       pipeline stall: hold all state and outputs
//  Flush                in   1       squash current ID op and EX output
//  Err_Clear            in   1       clear sticky error flags
//  Stack_Out_EX         out  ADDR_W  popped return address, valid in EX
//  Stack_Out_Enable_EX  out  1       1 = branch address comes from Stack_Out_EX
//  Stack_Count          out  CNT_W   occupied entries, 0..DEPTH
//  Stack_Full           out  1       Stack_Count == DEPTH (comb. from count)
//  Stack_Empty          out  1       Stack_Count == 0 (comb. from count)
//  Overflow_Err         out  1       sticky: CALL attempted while full
//  Underflow_Err        out  1       sticky: RET attempted while empty
// BEHAVIOUR
//  - Reset: count=0, Stack_Out_EX=0, Stack_Out_Enable_EX=0, both errors=0; entry RAM not cleared.
//  - Priority per cycle: rst > Flush > Stall > normal op.
//  - Flush: no push/pop, count unchanged, Stack_Out_Enable_EX<=0, Stack_Out_EX holds; errors unchanged
//    except Err_Clear still honoured.
//  - Stall (no Flush): every register holds, incl. Stack_Out_EX/Enable (EX op stays presented).
//  - Normal: Stack_Out_Enable_EX<=0 unless a valid pop occurs this cycle (1-cycle pulse per RET).
//  - Push only (Call & !Ret): if !full: mem[count]<=Return_Addr_ID, count+1.
//    if full: push dropped, count unchanged, Overflow_Err<=1.
//  - Pop only (Ret & !Call): if !empty: Stack_Out_EX<=mem[count-1], Enable<=1, count-1.
//    if empty: Stack_Out_EX<=0, Enable<=0, Underflow_Err<=1, count stays 0.
//  - Call & Ret same cycle, !empty: Stack_Out_EX<=old top, Enable<=1,
//    mem[count-1]<=Return_Addr_ID, count unchanged (valid even when full; no overflow).
//  - Call & Ret same cycle, empty: Underflow_Err<=1, Enable<=0, then push: mem[0]<=addr, count=1.
//  - Latency: RET in ID at cycle N -> Stack_Out_EX/Enable valid cycle N+1 (while not stalled).
//  - Count never wraps: saturates 0..DEPTH; pointer = count, no modular wrap.
//  - Err_Clear: errors<=0 unless a new error is set same cycle (set wins).
//  - Stack_Full/Empty combinational from count; never both 1.
//  - Reset mid-sequence discards contents; first RET after reset underflows.
// TESTING
//  1 rst; CALL 0x0010,0x0020,0x0030; RET x3 -> Stack_Out_EX 0x0030,0x0020,0x0010 each 1 cycle later,
//    Enable pulses 1 per RET, count 3->0, Stack_Empty=1.
//  2 DEPTH=8: 9 CALLs 0x0100..0x0108 -> count=8, Stack_Full=1, Overflow_Err=1; 8 RETs return 0x0107..0x0100.
//  3 RET while empty -> Enable=0, Stack_Out_EX=0, Underflow_Err=1 sticky; Err_Clear -> 0 next cycle.
//  4 count=2 (top 0x0AAA); Call+Ret with 0x0BBB -> Stack_Out_EX=0x0AAA, Enable=1, count=2;
//    next RET -> 0x0BBB.
//  5 RET with Stall high 3 cycles after pop -> Stack_Out_EX/Enable held, count unchanged;
//    Flush with RET -> Enable=0, count unchanged.
//  6 rst asserted after 4 pushes -> count=0, Enable=0, errors=0; following RET -> Underflow_Err=1.

Source files
------------

// File: rtl/return_stack_if.sv
// Signal bundle between the ID/EX pipeline and the return-address stack.
// The master drives ID-stage requests and pipeline control; the slave returns the EX-stage branch source and status.
interface return_stack_if #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 4
);
  logic              Call_ID;
  logic              Ret_ID;
  logic [ADDR_W-1:0] Return_Addr_ID;
  logic              Stall;
  logic              Flush;
  logic              Err_Clear;
  logic [ADDR_W-1:0] Stack_Out_EX;
  logic              Stack_Out_Enable_EX;
  logic [CNT_W-1:0]  Stack_Count;
  logic              Stack_Full;
  logic              Stack_Empty;
  logic              Overflow_Err;
  logic              Underflow_Err;

  modport master (
    output Call_ID, Ret_ID, Return_Addr_ID, Stall, Flush, Err_Clear,
    input  Stack_Out_EX, Stack_Out_Enable_EX, Stack_Count, Stack_Full, Stack_Empty,
           Overflow_Err, Underflow_Err
  );

  modport slave (
    input  Call_ID, Ret_ID, Return_Addr_ID, Stall, Flush, Err_Clear,
    output Stack_Out_EX, Stack_Out_Enable_EX, Stack_Count, Stack_Full, Stack_Empty,
           Overflow_Err, Underflow_Err
  );
endinterface

// File: rtl/return_stack_ctrl.sv
// Return-address stack: CALL pushes PC+1 in ID, RET pops the top into EX as the branch target.
// Count saturates at 0..DEPTH; misuse sets sticky overflow/underflow flags instead of wrapping.
module return_stack_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  return_stack_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] out_q, out_d;
  logic              en_q, en_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic              full, empty;
  logic [CNT_W-1:0]  cnt_m1;
  logic [PTR_W-1:0]  top_idx, push_idx, wr_idx;
  logic              wr_en;

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign cnt_m1   = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
  assign top_idx  = cnt_m1[PTR_W-1:0];
  assign push_idx = cnt_q[PTR_W-1:0];

  always_comb begin
    cnt_d  = cnt_q;
    out_d  = out_q;
    en_d   = en_q;
    ovf_d  = ovf_q;
    udf_d  = udf_q;
    wr_en  = 1'b0;
    wr_idx = push_idx;
    if (bus.Flush) begin
      en_d = 1'b0;
      if (bus.Err_Clear) begin
        ovf_d = 1'b0;
        udf_d = 1'b0;
      end
    end else if (!bus.Stall) begin
      en_d = 1'b0;
      if (bus.Err_Clear) begin
        ovf_d = 1'b0;
        udf_d = 1'b0;
      end
      if (bus.Call_ID && !bus.Ret_ID) begin
        if (!full) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          ovf_d = 1'b1;
        end
      end else if (bus.Ret_ID && !bus.Call_ID) begin
        if (!empty) begin
          out_d = mem_q[top_idx];
          en_d  = 1'b1;
          cnt_d = cnt_m1;
        end else begin
          out_d = '0;
          udf_d = 1'b1;
        end
      end else if (bus.Call_ID && bus.Ret_ID) begin
        // Simultaneous CALL+RET replaces the top in place, so depth is unchanged even when full.
        if (!empty) begin
          out_d  = mem_q[top_idx];
          en_d   = 1'b1;
          wr_en  = 1'b1;
          wr_idx = top_idx;
        end else begin
          udf_d  = 1'b1;
          wr_en  = 1'b1;
          wr_idx = '0;
          cnt_d  = {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      out_q <= '0;
      en_q  <= 1'b0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
      en_q  <= en_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  // Entry storage carries no reset; only count decides which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem_q[wr_idx] <= bus.Return_Addr_ID;
    end
  end

  assign bus.Stack_Out_EX        = out_q;
  assign bus.Stack_Out_Enable_EX = en_q;
  assign bus.Stack_Count         = cnt_q;
  assign bus.Stack_Full          = full;
  assign bus.Stack_Empty         = empty;
  assign bus.Overflow_Err        = ovf_q;
  assign bus.Underflow_Err       = udf_q;
endmodule
